// File: rtl/fft_sdf_sequencer_if.sv
// Control bundle between the SDF frame scheduler and the FFT datapath.
// The slave modport is the sequencer side; the master modport is the datapath/source side.
interface fft_sdf_sequencer_if;
    logic        in_valid;
    logic        in_zero;
    logic [4:0]  bf_sel;
    logic [19:0] tw_idx;
    logic [4:0]  stage_act;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic        out_sof;
    logic        out_eof;
    logic        busy;
    logic        err;

    modport master (
        output in_valid,
        input  in_zero, bf_sel, tw_idx, stage_act, out_valid, out_idx,
               out_sof, out_eof, busy, err
    );

    modport slave (
        input  in_valid,
        output in_zero, bf_sel, tw_idx, stage_act, out_valid, out_idx,
               out_sof, out_eof, busy, err
    );
endinterface

// File: rtl/fft_sdf_sequencer.sv
// Frame scheduler for the 32-point radix-2 DIF SDF FFT: per-stage select/twiddle/active,
// gap zero-padding, and bit-reversed output tagging.
module fft_sdf_sequencer (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_sdf_sequencer_if.slave    sif
);
    // Frames are 32 cycles apart at minimum and the longest window ends at relative
    // cycle 67, so at most three frames are ever in flight; track the age of each.
    localparam logic [6:0] AGE_MAX = 7'd127;
    localparam logic [6:0] OUT_LO  = 7'd36;
    localparam logic [6:0] OUT_HI  = 7'd67;
    localparam logic [6:0] ST_LO [5] = '{7'd0, 7'd17, 7'd26, 7'd31, 7'd34};
    localparam logic [6:0] ST_HI [5] = '{7'd47, 7'd56, 7'd61, 7'd64, 7'd66};

    logic [6:0]  age_q [3];
    logic [6:0]  age_d [3];
    logic [6:0]  cur [3];
    logic        opening;
    logic        gap;
    logic        gap_q;
    logic [4:0]  bf_d;
    logic [4:0]  act_d;
    logic [19:0] tw_d;
    logic        ov_d;
    logic [4:0]  m_d;

    // Newest frame is slot-counting while its age is 1..31; age 127 means no frame.
    assign opening     = sif.in_valid && (age_q[0] > 7'd31);
    assign gap         = !sif.in_valid && (age_q[0] <= 7'd31);
    assign sif.in_zero = gap;

    always_comb begin
        cur[0] = opening ? 7'd0     : age_q[0];
        cur[1] = opening ? age_q[0] : age_q[1];
        cur[2] = opening ? age_q[1] : age_q[2];
        for (int k = 0; k < 3; k++) begin
            age_d[k] = (cur[k] == AGE_MAX) ? AGE_MAX : cur[k] + 7'd1;
        end
    end

    always_comb begin
        logic [6:0] n;
        logic [3:0] mask;
        bf_d  = '0;
        act_d = '0;
        tw_d  = '0;
        ov_d  = 1'b0;
        m_d   = '0;
        n     = '0;
        mask  = '0;
        // Oldest first so the newest frame in a window overrides.
        for (int k = 2; k >= 0; k--) begin
            for (int s = 0; s < 5; s++) begin
                if (cur[k] >= ST_LO[s] && cur[k] <= ST_HI[s]) begin
                    n             = cur[k] - ST_LO[s];
                    mask          = 4'((16 >> s) - 1);
                    act_d[s]      = 1'b1;
                    bf_d[s]       = n[4 - s];
                    tw_d[4*s +: 4] = 4'((n[3:0] & mask) << s);
                end
            end
            if (cur[k] >= OUT_LO && cur[k] <= OUT_HI) begin
                ov_d = 1'b1;
                m_d  = 5'(cur[k] - OUT_LO);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) age_q[k] <= AGE_MAX;
            gap_q         <= 1'b0;
            sif.err       <= 1'b0;
            sif.bf_sel    <= '0;
            sif.tw_idx    <= '0;
            sif.stage_act <= '0;
            sif.out_valid <= 1'b0;
            sif.out_idx   <= '0;
            sif.out_sof   <= 1'b0;
            sif.out_eof   <= 1'b0;
            sif.busy      <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) age_q[k] <= age_d[k];
            gap_q         <= gap;
            sif.err       <= gap_q;
            sif.bf_sel    <= bf_d;
            sif.tw_idx    <= tw_d;
            sif.stage_act <= act_d;
            sif.out_valid <= ov_d;
            sif.out_idx   <= {m_d[0], m_d[1], m_d[2], m_d[3], m_d[4]};
            sif.out_sof   <= ov_d && (m_d == 5'd0);
            sif.out_eof   <= ov_d && (m_d == 5'd31);
            sif.busy      <= (|act_d) || ov_d;
        end
    end
endmodule
